led_scan_ctrl: RTL and testbench
================================

# led_scan_ctrl

Scan and buffer controller for the four-digit seven-segment display on the RS232 board. It accepts ASCII bytes from the UART receive path and keeps the last four received characters in a shift buffer. It time-multiplexes the buffer onto the ASCII-to-digit decoder by driving its `data` (character) and `sel` (digit index 0–3) inputs. A carriage return clears the display. A freeze input holds the displayed value and back-pressures the receiver.

## Interface
- `SCAN_DIV`, default 50000: clock cycles each digit is held before the scan advances; legal range 1 to 2^20−1.
- `CLR_CHAR`, default 8'h0D: byte value that clears the buffer instead of being stored.
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `rx_data`  in  8  received byte; meaningful only while `rx_valid`=1.
- `rx_valid`  in  1  byte available from the UART receiver.
- `rx_ready`  out  1  controller accepts a byte this cycle; a transfer occurs on a rising edge with `rx_valid` & `rx_ready`.
- `freeze`  in  1  hold the buffer contents; blocks acceptance.
- `data`  out  8  ASCII character for the currently selected digit (to the decoder).
- `sel`  out  4  digit index, 0–3 (to the decoder; values 4–15 never driven).
- `digit_cnt`  out  3  characters stored since reset or last clear, saturating at 4.

## Operation
- Buffer: four 8-bit registers, `buf0` (rightmost, newest) to `buf3` (oldest).
- Accept occurs when `rx_valid` & `rx_ready`.
  - Stored byte (not `CLR_CHAR`): `buf3`←`buf2`, `buf2`←`buf1`, `buf1`←`buf0`, `buf0`←`rx_data`; `digit_cnt` increments, saturating at 4.
  - `CLR_CHAR`: all buf←8'h30 ('0'); `digit_cnt`←0; nothing shifted.
  - Bytes are stored unfiltered. Non-digit characters are passed to the decoder, which renders them as its default glyph.
- `rx_ready` = registered `~freeze`. It falls the cycle after `freeze` rises and rises the cycle after `freeze` falls. It is 0 during reset and in the first cycle after reset.
- Scan divider `div` counts 0..`SCAN_DIV`−1 every cycle, then wraps to 0.
- `sel` advances at the wrap: 0→1→2→3→0.
- `data` is registered every cycle as `data` ← buf[`sel_next`], where `sel_next` is the value `sel` takes at the same edge. In steady state, `data` = buf[`sel`] as of the previous cycle.
- `freeze` does not stop the scan. Only the buffer is held.

## Timing
- Reset values (edge with `rst`=1):
  - all buf = 8'h30
  - `div`=0, `sel`=0, `data`=8'h30
  - `digit_cnt`=0, `rx_ready`=0
- Reset has priority over every other event, including mid-scan and mid-accept. An accept coincident with `rst`=1 is discarded.
- Accept latency: a byte accepted at edge N is in `buf0` after edge N. It appears on `data` after edge N+1 if `sel`=0 is selected then.
- Scan period: each `sel` value is held exactly `SCAN_DIV` cycles; a full frame is 4·`SCAN_DIV` cycles. The first advance (`sel` 0→1) occurs at the edge where `div`=`SCAN_DIV`−1, i.e. `SCAN_DIV` cycles after reset release.
- `SCAN_DIV`=1: `sel` advances every cycle.
- Simultaneous accept and scan advance: both take effect. `data` is loaded from the pre-shift buffer at the new `sel` and corrects on the next edge. A one-cycle stale value is permitted only in this case.
- Back-to-back accepts: one byte per cycle while `rx_ready`=1; no bubbles are required.
- `digit_cnt` at 4 plus a further accept: stays 4, and the oldest character is discarded.
- `CLR_CHAR` while `freeze`=1: not accepted, because `rx_ready`=0. The receiver must hold the byte.

## Test plan
- Reset and scan, `SCAN_DIV`=4: release `rst` → `sel` steps 0,1,2,3,0 every 4 cycles; `data`=8'h30 throughout; `rx_ready` goes 1 one cycle after release; `digit_cnt`=0.
- Shift-in: send '1','2','3','4','5' back-to-back (`rx_valid` held 5 cycles) → buf3..buf0 = '2','3','4','5'; `digit_cnt` reads 1,2,3,4,4; on the next frame `data` at `sel`=0..3 shows 8'h35, 8'h34, 8'h33, 8'h32.
- Clear: after the previous case, send 8'h0D → all digits 8'h30, `digit_cnt`=0; then send '9' → `buf0`=8'h39, `digit_cnt`=1.
- Freeze: assert `freeze` and present '7' with `rx_valid`=1 → `rx_ready`=0 from the next cycle, buffer unchanged, scan continues; deassert `freeze` → '7' is accepted exactly once.
- Collision: accept '8' at the same edge `sel` wraps 3→0 → `data` = old `buf0` for one cycle, then 8'h38.
- Mid-operation reset: assert `rst` for 1 cycle during an accept with `sel`=2 → next cycle all outputs hold reset values and the byte is not stored.

Source files
------------

// File: rtl/led_scan_ctrl.sv
// Four-character shift buffer scanned onto a 7-seg decoder; data/sel are registered (1 cycle behind buffer).
// Backpressure: rx_ready is ~freeze delayed one cycle; a frozen controller leaves the byte with the receiver.
module led_scan_ctrl #(
    parameter int unsigned SCAN_DIV = 50000,
    parameter logic [7:0]  CLR_CHAR = 8'h0D
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_ready,
    input  logic       freeze,
    output logic [7:0] data,
    output logic [3:0] sel,
    output logic [2:0] digit_cnt
);

    localparam logic [19:0] DIV_MAX = 20'(SCAN_DIV - 1);

    logic [7:0]  dbuf [4];
    logic [19:0] div;
    logic [1:0]  sel_q;
    logic [1:0]  sel_nxt;
    logic        wrap;
    logic        accept;

    always_comb begin
        wrap    = (div == DIV_MAX);
        sel_nxt = wrap ? sel_q + 2'd1 : sel_q;
        accept  = rx_valid & rx_ready;
    end

    assign sel = {2'b00, sel_q};

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) dbuf[i] <= 8'h30;
            div       <= '0;
            sel_q     <= '0;
            data      <= 8'h30;
            digit_cnt <= '0;
            rx_ready  <= 1'b0;
        end else begin
            rx_ready <= ~freeze;
            div      <= wrap ? '0 : div + 20'd1;
            sel_q    <= sel_nxt;
            // Loaded from the pre-shift buffer; an accept on a wrap edge shows stale for one cycle.
            data     <= dbuf[sel_nxt];
            if (accept) begin
                if (rx_data == CLR_CHAR) begin
                    for (int i = 0; i < 4; i++) dbuf[i] <= 8'h30;
                    digit_cnt <= '0;
                end else begin
                    dbuf[3] <= dbuf[2];
                    dbuf[2] <= dbuf[1];
                    dbuf[1] <= dbuf[0];
                    dbuf[0] <= rx_data;
                    if (digit_cnt != 3'd4) digit_cnt <= digit_cnt + 3'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_led_scan_ctrl.sv
// Directed bench for led_scan_ctrl with a cycle-level reference model checked on every falling edge.
module tb_led_scan_ctrl;

    localparam int SD = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       freeze;
    logic [7:0] data;
    logic [3:0] sel;
    logic [2:0] digit_cnt;

    led_scan_ctrl #(.SCAN_DIV(SD), .CLR_CHAR(8'h0D)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .freeze(freeze), .data(data), .sel(sel),
        .digit_cnt(digit_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Reference model: buffer as a plain array, scan position from elapsed cycles.
    logic [7:0] mb [4];
    logic [7:0] old_b [4];
    logic [7:0] mdata;
    int         m_t, msel, mcnt;
    logic       m_rdy;
    logic       m_init = 1'b0;

    always @(posedge clk) begin
        m_init = 1'b1;
        if (rst) begin
            for (int i = 0; i < 4; i++) mb[i] = 8'h30;
            m_t = 0; msel = 0; mcnt = 0; mdata = 8'h30; m_rdy = 1'b0;
        end else begin
            old_b = mb;
            m_t++;
            msel  = (m_t / SD) % 4;
            mdata = old_b[msel];
            if (rx_valid && m_rdy) begin
                if (rx_data == 8'h0D) begin
                    for (int i = 0; i < 4; i++) mb[i] = 8'h30;
                    mcnt = 0;
                end else begin
                    mb[3] = old_b[2]; mb[2] = old_b[1]; mb[1] = old_b[0]; mb[0] = rx_data;
                    if (mcnt < 4) mcnt++;
                end
            end
            m_rdy = !freeze;
        end
    end

    always @(negedge clk) begin
        if (m_init) begin
            chk("sel", 32'(sel), 32'(msel));
            chk("data", 32'(data), 32'(mdata));
            chk("digit_cnt", 32'(digit_cnt), 32'(mcnt));
            chk("rx_ready", 32'(rx_ready), 32'(m_rdy));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    logic [7:0] seen [4];
    task automatic capture();
        repeat (4 * SD) begin
            tick(1);
            seen[sel[1:0]] = data;
        end
    endtask

    int n;
    logic [2:0] cnt_exp [5];

    initial begin
        cnt_exp = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
        rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; freeze = 1'b0;
        tick(2);
        chk("rst_data", 32'(data), 32'h30);
        chk("rst_sel", 32'(sel), 0);
        chk("rst_cnt", 32'(digit_cnt), 0);
        chk("rst_ready", 32'(rx_ready), 0);
        rst = 1'b0;

        // Scan after release
        tick(1);
        chk("ready_after_rel", 32'(rx_ready), 1);
        tick(2); chk("scan_k3", 32'(sel), 0);
        tick(1); chk("scan_k4", 32'(sel), 1);
        tick(4); chk("scan_k8", 32'(sel), 2);
        tick(4); chk("scan_k12", 32'(sel), 3);
        tick(4); chk("scan_k16", 32'(sel), 0);
        chk("scan_data", 32'(data), 32'h30);

        // Back-to-back shift-in
        rx_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            rx_data = 8'h31 + 8'(i);
            tick(1);
            chk("shift_cnt", 32'(digit_cnt), 32'(cnt_exp[i]));
        end
        rx_valid = 1'b0;
        chk("model_buf0", 32'(mb[0]), 32'h35);
        chk("model_buf3", 32'(mb[3]), 32'h32);
        capture();
        chk("shift_d0", 32'(seen[0]), 32'h35);
        chk("shift_d1", 32'(seen[1]), 32'h34);
        chk("shift_d2", 32'(seen[2]), 32'h33);
        chk("shift_d3", 32'(seen[3]), 32'h32);

        // Clear then one digit
        rx_valid = 1'b1; rx_data = 8'h0D;
        tick(1); chk("clr_cnt", 32'(digit_cnt), 0);
        rx_data = 8'h39;
        tick(1); chk("clr_9_cnt", 32'(digit_cnt), 1);
        rx_valid = 1'b0;
        capture();
        chk("clr_d0", 32'(seen[0]), 32'h39);
        chk("clr_d1", 32'(seen[1]), 32'h30);
        chk("clr_d2", 32'(seen[2]), 32'h30);
        chk("clr_d3", 32'(seen[3]), 32'h30);

        // Freeze holds the buffer and the byte
        freeze = 1'b1;
        tick(1); chk("frz_ready", 32'(rx_ready), 0);
        rx_valid = 1'b1; rx_data = 8'h37;
        tick(6); chk("frz_cnt", 32'(digit_cnt), 1);
        freeze = 1'b0;
        n = 0;
        while (!rx_ready && n < 10) begin tick(1); n++; end
        chk("frz_wait", 32'(n < 10), 1);
        tick(1);
        rx_valid = 1'b0;
        chk("unfrz_cnt", 32'(digit_cnt), 2);
        tick(3); chk("unfrz_once", 32'(digit_cnt), 2);
        chk("model_after_frz", 32'({mb[1], mb[0]}), 32'h3937);

        // Accept coincident with the 3->0 wrap
        n = 0;
        while (((m_t + 1) % (4 * SD)) != 0 && n < 40) begin tick(1); n++; end
        chk("coll_wait", 32'(n < 40), 1);
        rx_valid = 1'b1; rx_data = 8'h38;
        tick(1);
        rx_valid = 1'b0;
        chk("coll_sel", 32'(sel), 0);
        chk("coll_stale", 32'(data), 32'h37);
        tick(1); chk("coll_fixed", 32'(data), 32'h38);

        // Reset during an accept at sel=2
        n = 0;
        while (sel != 4'd2 && n < 40) begin tick(1); n++; end
        chk("mrst_wait", 32'(n < 40), 1);
        rx_valid = 1'b1; rx_data = 8'h35; rst = 1'b1;
        tick(1);
        chk("mrst_data", 32'(data), 32'h30);
        chk("mrst_sel", 32'(sel), 0);
        chk("mrst_cnt", 32'(digit_cnt), 0);
        chk("mrst_ready", 32'(rx_ready), 0);
        rst = 1'b0; rx_valid = 1'b0;
        capture();
        chk("mrst_d0", 32'(seen[0]), 32'h30);
        chk("mrst_d3", 32'(seen[3]), 32'h30);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
